// File: rtl/bc_round_ctrl.sv
// Bulls/cows round controller: gates the comparator via save, tallies each guess,
// counts attempts and reports WIN/LOSE for the display logic.
module bc_round_ctrl #(
    parameter int unsigned MAX_TRIES = 8,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             lock_secret,
    input  logic             submit,
    input  logic [3:0]       bulls,
    input  logic [3:0]       cows,
    output logic             save,
    output logic [2:0]       bull_cnt,
    output logic [2:0]       cow_cnt,
    output logic [CNT_W-1:0] attempts,
    output logic             result_valid,
    output logic             win,
    output logic             lose,
    output logic [2:0]       state
);

    localparam int unsigned POS_W = 4;
    localparam int unsigned SUM_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PLAY  = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    state_t           state_q;
    logic [POS_W-1:0] cows_only;
    logic [SUM_W-1:0] bull_sum;
    logic [SUM_W-1:0] cow_sum;
    logic [CNT_W-1:0] attempts_inc;

    // A position flagged as both bull and cow counts only as a bull.
    always_comb begin
        cows_only    = cows & ~bulls;
        bull_sum     = '0;
        cow_sum      = '0;
        for (int i = 0; i < int'(POS_W); i++) begin
            bull_sum = bull_sum + SUM_W'(bulls[i]);
            cow_sum  = cow_sum + SUM_W'(cows_only[i]);
        end
        attempts_inc = attempts + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            save         <= 1'b1;
            bull_cnt     <= '0;
            cow_cnt      <= '0;
            attempts     <= '0;
            result_valid <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (start) begin
                // start aborts any round, dropping a concurrent submit
                state_q  <= ST_SETUP;
                save     <= 1'b1;
                bull_cnt <= '0;
                cow_cnt  <= '0;
                attempts <= '0;
                win      <= 1'b0;
                lose     <= 1'b0;
            end else begin
                case (state_q)
                    ST_SETUP: begin
                        if (lock_secret) begin
                            state_q <= ST_PLAY;
                            save    <= 1'b0;
                        end
                    end
                    ST_PLAY: begin
                        if (submit) begin
                            bull_cnt     <= bull_sum;
                            cow_cnt      <= cow_sum;
                            attempts     <= attempts_inc;
                            result_valid <= 1'b1;
                            if (bull_sum == SUM_W'(POS_W)) begin
                                state_q <= ST_WIN;
                                save    <= 1'b1;
                                win     <= 1'b1;
                            end else if (attempts_inc == CNT_W'(MAX_TRIES)) begin
                                state_q <= ST_LOSE;
                                save    <= 1'b1;
                                lose    <= 1'b1;
                            end
                        end
                    end
                    ST_IDLE, ST_WIN, ST_LOSE: begin
                        state_q <= state_q;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        save    <= 1'b1;
                        win     <= 1'b0;
                        lose    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_bc_round_ctrl.sv
// Bench for bc_round_ctrl: directed scenarios then randomized traffic, all
// checked every cycle against a round-level behavioural model.
module tb_bc_round_ctrl;

    localparam int unsigned MAX   = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             lock_secret = 1'b0;
    logic             submit = 1'b0;
    logic [3:0]       bulls = '0;
    logic [3:0]       cows = '0;
    logic             save;
    logic [2:0]       bull_cnt;
    logic [2:0]       cow_cnt;
    logic [CNT_W-1:0] attempts;
    logic             result_valid;
    logic             win;
    logic             lose;
    logic [2:0]       state;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 setup, 2 play, 3 win, 4 lose
    int m_mode = 0;
    int m_bulls = 0;
    int m_cows = 0;
    int m_att = 0;
    int m_rv = 0;

    bc_round_ctrl #(.MAX_TRIES(MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .lock_secret(lock_secret),
        .submit(submit), .bulls(bulls), .cows(cows), .save(save),
        .bull_cnt(bull_cnt), .cow_cnt(cow_cnt), .attempts(attempts),
        .result_valid(result_valid), .win(win), .lose(lose), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_bulls = 0; m_cows = 0; m_att = 0; m_rv = 0;
        end else begin
            m_rv = 0;
            if (start) begin
                m_mode = 1; m_bulls = 0; m_cows = 0; m_att = 0;
            end else if (m_mode == 1 && lock_secret) begin
                m_mode = 2;
            end else if (m_mode == 2 && submit) begin
                m_bulls = $countones(bulls);
                m_cows  = $countones(cows & ~bulls);
                m_att   = m_att + 1;
                m_rv    = 1;
                if (m_bulls == 4) m_mode = 3;
                else if (m_att == int'(MAX)) m_mode = 4;
            end
        end
    endtask

    task automatic check_all();
        chk("state", 16'(state), 16'(m_mode));
        chk("save", 16'(save), 16'(m_mode != 2));
        chk("bull_cnt", 16'(bull_cnt), 16'(m_bulls));
        chk("cow_cnt", 16'(cow_cnt), 16'(m_cows));
        chk("attempts", 16'(attempts), 16'(m_att));
        chk("result_valid", 16'(result_valid), 16'(m_rv));
        chk("win", 16'(win), 16'(m_mode == 3));
        chk("lose", 16'(lose), 16'(m_mode == 4));
    endtask

    // One clock: model sees the same inputs as the DUT edge, outputs checked 1ns later.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
        rst = 1'b0; start = 1'b0; lock_secret = 1'b0; submit = 1'b0;
    endtask

    task automatic go_play();
        start = 1'b1; cyc();
        lock_secret = 1'b1; cyc();
    endtask

    task automatic guess(input logic [3:0] b, input logic [3:0] c);
        bulls = b; cows = c; submit = 1'b1; cyc();
    endtask

    initial begin
        #1;
        rst = 1'b1; cyc();
        rst = 1'b1; cyc();
        // immediate win on the first guess
        go_play();
        guess(4'b1111, 4'b0000);
        chk("t1_win", 16'(win), 16'd1);
        cyc();
        // overlapping bull/cow flags
        go_play();
        guess(4'b0001, 4'b0111);
        chk("t2_cow", 16'(cow_cnt), 16'd2);
        // lose after MAX tries, then an ignored extra submit
        go_play();
        for (int i = 0; i < int'(MAX); i++) guess(4'b0011, 4'($urandom));
        chk("t3_lose", 16'(lose), 16'd1);
        guess(4'b0011, 4'b0000);
        chk("t3_att", 16'(attempts), 16'(MAX));
        // win on the last allowed guess
        go_play();
        for (int i = 0; i < int'(MAX) - 1; i++) guess(4'b0101, 4'b0010);
        guess(4'b1111, 4'b0000);
        chk("t4_win", 16'(win), 16'd1);
        chk("t4_lose", 16'(lose), 16'd0);
        // start with submit mid-play
        go_play();
        for (int i = 0; i < 3; i++) guess(4'($urandom_range(0, 14)), 4'($urandom));
        start = 1'b1; submit = 1'b1; bulls = 4'b1111; cyc();
        chk("t5_state", 16'(state), 16'd1);
        // ignored pulses in idle, reset beats start
        rst = 1'b1; cyc();
        submit = 1'b1; lock_secret = 1'b1; cyc();
        chk("t6_idle", 16'(state), 16'd0);
        go_play();
        rst = 1'b1; start = 1'b1; cyc();
        chk("t6_rst", 16'(state), 16'd0);
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 199) == 0);
            start       = ($urandom_range(0, 39) == 0);
            lock_secret = ($urandom_range(0, 3) == 0);
            submit      = ($urandom_range(0, 1) == 0);
            bulls       = ($urandom_range(0, 5) == 0) ? 4'b1111 : 4'($urandom);
            cows        = 4'($urandom);
            cyc();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
